// File: rtl/dct_pkg.sv
// Shared constants and types for the 2-D DCT datapath.
// Block geometry is fixed at 8x8; coefficient width defaults to 16.
package dct_pkg;

    localparam int N      = 8;
    localparam int IDX_W  = 3;
    localparam int COEF_W = 16;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t vec_t [N];

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: writes a whole row per cycle,
// reads a whole column per cycle (combinational read).
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_row,
    input  logic [DATA_W-1:0] wr_data [N],
    input  logic [IDX_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data [N]
);

    logic [DATA_W-1:0] mem [N][N];

    // Contents are deliberately left unreset; full flags gate their use.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < N; k++) begin
                mem[wr_row][k] <= wr_data[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rd_data[k] = mem[k][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer between row and column DCT passes.
// Rows in, columns out, one vector per cycle each way.
module dct_transpose_8x8
    import dct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7
);

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_row;
    logic [IDX_W-1:0]  rd_col;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_last;
    logic              rd_last;
    logic [DATA_W-1:0] in_vec  [N];
    logic [DATA_W-1:0] rd_vec0 [N];
    logic [DATA_W-1:0] rd_vec1 [N];
    logic [DATA_W-1:0] out_vec [N];

    assign in_vec[0] = in0;
    assign in_vec[1] = in1;
    assign in_vec[2] = in2;
    assign in_vec[3] = in3;
    assign in_vec[4] = in4;
    assign in_vec[5] = in5;
    assign in_vec[6] = in6;
    assign in_vec[7] = in7;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_last   = wr_row == LAST_IDX;
    assign rd_last   = rd_col == LAST_IDX;

    dct_tp_bank #(
        .DATA_W (DATA_W)
    ) u_bank0 (
        .clk     (clk),
        .we      (wr_fire && !wr_bank),
        .wr_row  (wr_row),
        .wr_data (in_vec),
        .rd_col  (rd_col),
        .rd_data (rd_vec0)
    );

    dct_tp_bank #(
        .DATA_W (DATA_W)
    ) u_bank1 (
        .clk     (clk),
        .we      (wr_fire && wr_bank),
        .wr_row  (wr_row),
        .wr_data (in_vec),
        .rd_col  (rd_col),
        .rd_data (rd_vec1)
    );

    // Set and clear always hit different banks: a bank is only
    // written while empty and only read while full.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_row <= wr_row + 1'b1;
                if (wr_last) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_col + 1'b1;
                if (rd_last) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            out_vec[k] = '0;
            if (out_valid) begin
                out_vec[k] = rd_bank ? rd_vec1[k] : rd_vec0[k];
            end
        end
    end

    assign out0 = out_vec[0];
    assign out1 = out_vec[1];
    assign out2 = out_vec[2];
    assign out3 = out_vec[3];
    assign out4 = out_vec[4];
    assign out5 = out_vec[5];
    assign out6 = out_vec[6];
    assign out7 = out_vec[7];

endmodule

// File: tb/tb_dct_transpose_8x8.sv
// Directed bench for the ping-pong transpose buffer.
// Lane k of a packed 128-bit vector sits at bits [16k+15:16k].
module tb_dct_transpose_8x8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_row;
    logic         in_ready;
    logic         out_valid;
    logic [15:0]  out0, out1, out2, out3, out4, out5, out6, out7;
    logic [127:0] out_pk;

    int n_vec = 0;
    int n_err = 0;
    int n_cols = 0;

    logic [127:0] exp_q [$];
    logic [127:0] part [8];
    logic [127:0] mcol;
    int           part_n = 0;
    logic         done;

    always #5 clk = ~clk;

    assign out_pk = {out7, out6, out5, out4, out3, out2, out1, out0};

    dct_transpose_8x8 #(
        .DATA_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in_row[15:0]),
        .in1       (in_row[31:16]),
        .in2       (in_row[47:32]),
        .in3       (in_row[63:48]),
        .in4       (in_row[79:64]),
        .in5       (in_row[95:80]),
        .in6       (in_row[111:96]),
        .in7       (in_row[127:112]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat0(input int r);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = {4'h0, 4'(r), 4'h0, 4'(k)};
        return v;
    endfunction

    function automatic logic [127:0] patb(input int b, input int r);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = {4'(b), 4'h0, 4'(r), 4'(k)};
        return v;
    endfunction

    // Column 0 of a block built by patb: lane k = row k, col 0.
    function automatic logic [127:0] colb0(input int b);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = {4'(b), 4'h0, 4'(k), 4'h0};
        return v;
    endfunction

    function automatic logic [127:0] pat_ext(input int r);
        logic [127:0] v;
        for (int k = 0; k < 8; k++)
            v[16*k +: 16] = ((r + k) % 2 == 1) ? 16'h7FFF : 16'h8000;
        return v;
    endfunction

    // Reference model: collect accepted rows, queue transposed columns.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part_n = 0;
        end else begin
            if (in_valid && in_ready) begin
                part[part_n] = in_row;
                part_n++;
                if (part_n == 8) begin
                    for (int c = 0; c < 8; c++) begin
                        for (int k = 0; k < 8; k++)
                            mcol[16*k +: 16] = part[k][16*c +: 16];
                        exp_q.push_back(mcol);
                    end
                    part_n = 0;
                end
            end
            if (out_valid && out_ready) begin
                n_cols++;
                if (exp_q.size() == 0)
                    chk("col_avail", 128'(exp_q.size()), 128'd1);
                else
                    chk("col_data", out_pk, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [127:0] row);
        logic acc;
        int   t;
        in_row   = row;
        in_valid = 1'b1;
        acc      = 1'b0;
        t        = 0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = in_ready;
            step();
            t++;
        end
        in_valid = 1'b0;
        chk("row_accept", {127'b0, acc}, 128'd1);
    endtask

    task automatic wait_drain();
        int t;
        t        = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            step();
            t++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] hold;
        logic         acc;
        int           idx;
        int           c0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        done      = 1'b0;
        hold      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out", out_pk, 128'd0);
        step();
        rst_n = 1'b1;

        // Single block with first-column latency
        out_ready = 1'b1;
        for (int r = 0; r < 7; r++) send_row(pat0(r));
        in_row   = pat0(7);
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_pre", {127'b0, out_valid}, 128'd0);
        chk("row7_ready", {127'b0, in_ready}, 128'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_post", {127'b0, out_valid}, 128'd1);
        chk("single_col0", out_pk, {16'h0700, 16'h0600, 16'h0500, 16'h0400,
                                    16'h0300, 16'h0200, 16'h0100, 16'h0000});
        wait_drain();
        chk("idle_valid", {127'b0, out_valid}, 128'd0);

        // Back-to-back: four blocks streamed with no bubble
        out_ready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            for (int r = 0; r < 8; r++) begin
                in_row   = patb(b, r);
                in_valid = 1'b1;
                @(negedge clk);
                chk("b2b_ready", {127'b0, in_ready}, 128'd1);
                step();
            end
        end
        c0 = n_cols;
        wait_drain();
        chk("b2b_tail_cols", 128'(n_cols - c0), 128'd8);

        // Backpressure: both banks fill, writer stalls, output holds
        out_ready = 1'b0;
        idx       = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_row   = patb(5 + idx / 8, idx % 8);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (cyc == 10) hold = out_pk;
            step();
            if (acc) idx++;
        end
        chk("bp_accepted", 128'(idx), 128'd16);
        @(negedge clk);
        chk("bp_ready", {127'b0, in_ready}, 128'd0);
        chk("bp_valid", {127'b0, out_valid}, 128'd1);
        chk("bp_stable", out_pk, hold);
        chk("bp_col0", hold, colb0(5));
        out_ready = 1'b1;
        c0 = n_cols;
        while (idx < 24) begin
            send_row(patb(5 + idx / 8, idx % 8));
            idx++;
        end
        wait_drain();
        chk("bp_cols", 128'(n_cols - c0), 128'd24);

        // Extremes: most negative / most positive alternating
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) send_row(pat_ext(r));
        @(negedge clk);
        chk("ext_col0", out_pk, {16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                                 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000});
        wait_drain();

        // Reset mid-block: one full block plus 5 rows are discarded
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) send_row(patb(8, r));
        for (int r = 0; r < 5; r++) send_row(patb(9, r));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {127'b0, out_valid}, 128'd0);
        chk("mid_rst_ready", {127'b0, in_ready}, 128'd1);
        chk("mid_rst_out", out_pk, 128'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) send_row(patb(10, r));
        @(negedge clk);
        chk("post_rst_valid", {127'b0, out_valid}, 128'd1);
        chk("post_rst_col0", out_pk, colb0(10));
        wait_drain();

        // Random stalls on both sides, 100 blocks
        c0 = n_cols;
        fork
            begin
                for (int i = 0; i < 800; i++) begin
                    while ($urandom_range(1, 0) == 0) begin
                        in_valid = 1'b0;
                        step();
                    end
                    send_row({$urandom, $urandom, $urandom, $urandom});
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(1, 0));
                    step();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("rand_cols", 128'(n_cols - c0), 128'd800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
